i2s_xmit: RTL and testbench



---
 rtl/i2s_xmit.sv | 130 +++++++++++++
 tb/tb_i2s_xmit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_xmit.sv
`default_nettype none
// ============================================================================
// Module   : i2s_xmit
// Brief    : I2S transmitter, stereo DATA_W-bit samples, one-deep holding reg.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_xmit #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              mck,
    input  logic              reset,
    input  logic              bck,
    input  logic              lrck,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic              valid_in,
    output logic              ready,
    output logic              sdout,
    output logic              underrun
);

    localparam int                CNT_W    = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_DATA = CNT_W'(DATA_W);

    logic              bck_q, bck_d;
    logic              lrck_last_q, lrck_last_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] act_l_q, act_l_d;
    logic [DATA_W-1:0] act_r_q, act_r_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sdout_q, sdout_d;
    logic              underrun_q, underrun_d;

    logic              w_fall;
    logic              w_slot_start;

    assign w_fall       = bck_q & ~bck;
    assign w_slot_start = w_fall & (lrck != lrck_last_q);

    always_comb begin
        bck_d       = bck;
        lrck_last_d = lrck_last_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        sdout_d     = sdout_q;
        underrun_d  = 1'b0;

        if (valid_in && !hold_full_q) begin
            hold_l_d    = left_in;
            hold_r_d    = right_in;
            hold_full_d = 1'b1;
        end

        // Slot start emits the I2S delay bit and preempts any unsent bits.
        if (w_slot_start) begin
            lrck_last_d = lrck;
            bit_cnt_d   = '0;
            sdout_d     = 1'b0;
            if (!lrck) begin
                if (hold_full_q) begin
                    act_l_d     = hold_l_q;
                    act_r_d     = hold_r_q;
                    hold_full_d = 1'b0;
                    shift_d     = hold_l_q;
                end else begin
                    act_l_d    = '0;
                    act_r_d    = '0;
                    shift_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                shift_d = act_r_q;
            end
        end else if (w_fall) begin
            if (bit_cnt_q < CNT_DATA) begin
                sdout_d = shift_q[DATA_W-1];
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
            end else begin
                sdout_d = 1'b0;
            end
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge mck or posedge reset) begin
        if (reset) begin
            bck_q       <= 1'b0;
            lrck_last_q <= 1'b1;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sdout_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bck_q       <= bck_d;
            lrck_last_q <= lrck_last_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sdout_q     <= sdout_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ready    = ~hold_full_q;
    assign sdout    = sdout_q;
    assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_xmit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2s_xmit
// Brief    : Self-checking bench for i2s_xmit against a slot-level stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_xmit;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;

    logic              mck      = 1'b0;
    logic              reset    = 1'b1;
    logic              bck      = 1'b1;
    logic              lrck     = 1'b1;
    logic [DATA_W-1:0] left_in  = '0;
    logic [DATA_W-1:0] right_in = '0;
    logic              valid_in = 1'b0;
    logic              ready;
    logic              sdout;
    logic              underrun;

    i2s_xmit #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .mck      (mck),
        .reset    (reset),
        .bck      (bck),
        .lrck     (lrck),
        .left_in  (left_in),
        .right_in (right_in),
        .valid_in (valid_in),
        .ready    (ready),
        .sdout    (sdout),
        .underrun (underrun)
    );

    always #5 mck = ~mck;

    int n_tests = 0;
    int n_fail  = 0;

    // bck/lrck source: bck period 4 mck, lrck toggles on a bck fall
    int ph       = 0;
    int fcnt     = 0;
    int slot_len = 32;
    bit rand_len = 1'b0;

    // Reference model: stereo sample queue of depth one plus per-slot bit stream
    bit                m_empty;
    logic [DATA_W-1:0] m_hl, m_hr, m_al, m_ar;
    bit                m_lrck_last;
    bit                prev_bck;
    logic [63:0]       col;
    int                ncol;
    logic [DATA_W-1:0] slot_s;
    int                n_lstart = 0;
    bit                last_acc;

    bit                arm = 1'b0;
    logic [DATA_W-1:0] arm_l, arm_r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected slot stream of n falls: delay bit, DATA_W bits MSB first, zeros after.
    function automatic logic [63:0] exp_bits(input logic [DATA_W-1:0] s, input int n);
        logic [63:0] r;
        logic        b;
        r = '0;
        for (int k = 1; k <= n; k++) begin
            b = (k >= 2 && k <= DATA_W + 1) ? s[DATA_W-1-(k-2)] : 1'b0;
            r = {r[62:0], b};
        end
        return r;
    endfunction

    task automatic model_reset();
        m_empty     = 1'b1;
        m_hl        = '0;
        m_hr        = '0;
        m_al        = '0;
        m_ar        = '0;
        m_lrck_last = 1'b1;
        prev_bck    = 1'b0;
        col         = '0;
        ncol        = 0;
        slot_s      = '0;
    endtask

    // One mck cycle; entered and left at a negedge of mck.
    task automatic tick();
        bit f, st, acc, und_e, pulse;
        pulse = 1'b0;
        ph  = (ph + 1) % 4;
        bck = (ph < 2);
        if (ph == 2) begin
            if (fcnt >= slot_len) begin
                lrck = ~lrck;
                fcnt = 1;
                if (rand_len) begin
                    case ($urandom_range(0, 3))
                        0:       slot_len = 16;
                        1:       slot_len = 25;
                        2:       slot_len = 32;
                        default: slot_len = 40;
                    endcase
                end
            end else begin
                fcnt++;
            end
        end
        f     = !reset && prev_bck && !bck;
        st    = f && (lrck != m_lrck_last);
        acc   = 1'b0;
        und_e = 1'b0;
        if (arm && st && !lrck) begin
            valid_in = 1'b1;
            left_in  = arm_l;
            right_in = arm_r;
            arm      = 1'b0;
            pulse    = 1'b1;
        end
        if (!reset) begin
            acc   = valid_in && m_empty;
            und_e = st && !lrck && m_empty;
            if (st) begin
                chk("slot_stream", col, exp_bits(slot_s, ncol));
                col  = '0;
                ncol = 0;
                if (!lrck) begin
                    n_lstart++;
                    if (!m_empty) begin
                        m_al    = m_hl;
                        m_ar    = m_hr;
                        m_empty = 1'b1;
                    end else begin
                        m_al = '0;
                        m_ar = '0;
                    end
                    slot_s = m_al;
                end else begin
                    slot_s = m_ar;
                end
                m_lrck_last = lrck;
            end
            if (acc) begin
                m_hl    = left_in;
                m_hr    = right_in;
                m_empty = 1'b0;
            end
            prev_bck = bck;
        end else begin
            model_reset();
        end
        last_acc = acc;
        @(posedge mck);
        #1;
        if (f && ncol < 64) begin
            col = {col[62:0], sdout};
            ncol++;
        end
        chk("underrun", underrun, reset ? 1'b0 : und_e);
        chk("ready", ready, reset ? 1'b1 : m_empty);
        @(negedge mck);
        if (pulse) valid_in = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int  t;
        bit  done;
        valid_in = 1'b1;
        left_in  = l;
        right_in = r;
        done     = 1'b0;
        t        = 0;
        while (!done && t < 2000) begin
            tick();
            done = last_acc;
            t++;
        end
        valid_in = 1'b0;
        chk("write_accepted", done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nval;
        int t;
        model_reset();
        fcnt = slot_len - 3;
        @(negedge mck);
        run(3);
        reset = 1'b0;
        #1;
        chk("reset_sdout", sdout, 1'b0);
        chk("reset_underrun", underrun, 1'b0);
        chk("reset_ready", ready, 1'b1);

        // Known pattern through one full frame
        write(24'hA5F00F, 24'h5A0FF0);
        run(600);

        // No producer: muted frames with an underrun per left start
        run(600);

        // Write landing on the left-start cycle with the register empty
        arm_l = 24'h800000;
        arm_r = 24'h000001;
        arm   = 1'b1;
        run(800);
        chk("armed_write_fired", arm, 1'b0);

        // Continuous producer with incrementing samples
        nval     = 1;
        valid_in = 1'b1;
        left_in  = 24'(nval);
        right_in = 24'(nval);
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (last_acc) begin
                nval++;
                left_in  = 24'(nval);
                right_in = 24'(nval);
            end
        end
        valid_in = 1'b0;
        chk("continuous_accepts", (nval - 1 >= 4 && nval - 1 <= 6), 1'b1);

        // Reset in the middle of a right slot
        run(300);
        write(24'h000000, 24'hFFFFFF);
        t = n_lstart;
        for (int i = 0; i < 3000 && n_lstart == t; i++) tick();
        for (int i = 0; i < 3000 && !(lrck && fcnt == 11 && ph == 2); i++) tick();
        chk("pre_reset_bit", sdout, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_reset_sdout", sdout, 1'b0);
        chk("async_reset_ready", ready, 1'b1);
        model_reset();
        @(negedge mck);
        run(3);
        reset = 1'b0;
        write($urandom, $urandom);
        run(700);

        // Short slots: 16 bck per channel
        slot_len = 16;
        valid_in = 1'b1;
        left_in  = 24'hFFFFFF;
        right_in = 24'hFFFFFF;
        run(700);
        valid_in = 1'b0;
        slot_len = 32;
        run(300);

        // Random producer with varying slot lengths (short, exact, nominal, long)
        rand_len = 1'b1;
        for (int i = 0; i < 3500; i++) begin
            if (!valid_in && $urandom_range(0, 7) == 0) begin
                valid_in = 1'b1;
                left_in  = $urandom;
                right_in = $urandom;
            end
            tick();
            if (last_acc) valid_in = 1'b0;
        end
        valid_in = 1'b0;
        rand_len = 1'b0;
        run(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
